// File: rtl/alu_ctrl_sequencer_if.sv
// ALU control-step interface: instruction inputs from memory/IR and the
// datapath enables, register-select controls and one-hot ALU strobes.
interface alu_ctrl_sequencer_if;
   logic        run;
   logic        mem_ready;
   logic [31:0] ir;
   logic        PCout, PCin, MARin, MDRin, MDRout, Read, IRin;
   logic        Yin, Zin, Zlowout, Zhighout, LOin, HIin;
   logic        Gra, Grb, Grc, Rin, Rout;
   logic [13:0] alu_op;
   logic        busy;
   logic        fault;

   modport master (
      input  run, mem_ready, ir,
      output PCout, PCin, MARin, MDRin, MDRout, Read, IRin,
      output Yin, Zin, Zlowout, Zhighout, LOin, HIin,
      output Gra, Grb, Grc, Rin, Rout, alu_op, busy, fault
   );

   modport slave (
      output run, mem_ready, ir,
      input  PCout, PCin, MARin, MDRin, MDRout, Read, IRin,
      input  Yin, Zin, Zlowout, Zhighout, LOin, HIin,
      input  Gra, Grb, Grc, Rin, Rout, alu_op, busy, fault
   );
endinterface

// File: rtl/alu_ctrl_sequencer.sv
// Control-step sequencer for ALU-class instructions: fetch, decode, then step
// the Y/Z/HI/LO/register-file enables with a one-hot ALU strobe.
module alu_ctrl_sequencer #(
   parameter int MEM_TIMEOUT = 16
) (
   input  logic                        clock,
   input  logic                        clear_n,
   alu_ctrl_sequencer_if.master        bus
);

   typedef enum logic [3:0] {
      S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_FAULT
   } state_t;

   state_t      state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [13:0] op_q, op_d;
   logic [13:0] dec;
   logic        unary;
   logic        muldiv;

   always_comb begin
      dec = '0;
      case (bus.ir[31:27])
         5'b00011: dec[0]  = 1'b1;
         5'b00100: dec[1]  = 1'b1;
         5'b01111: dec[2]  = 1'b1;
         5'b10000: dec[3]  = 1'b1;
         5'b01010: dec[4]  = 1'b1;
         5'b01011: dec[5]  = 1'b1;
         5'b00101: dec[6]  = 1'b1;
         5'b00110: dec[7]  = 1'b1;
         5'b00111: dec[8]  = 1'b1;
         5'b01000: dec[9]  = 1'b1;
         5'b01001: dec[10] = 1'b1;
         5'b10001: dec[11] = 1'b1;
         5'b10010: dec[12] = 1'b1;
         default:  dec     = '0;
      endcase
   end

   assign unary  = dec[11] | dec[12];
   assign muldiv = op_q[2] | op_q[3];

   // The opcode is latched in T3 so later steps never depend on ir again.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      case (state_q)
         S_IDLE: if (bus.run) state_d = S_T0;
         S_T0: begin
            state_d = S_T1;
            cnt_d   = '0;
         end
         S_T1: begin
            if (bus.mem_ready) begin
               state_d = S_T2;
            end else if (cnt_q == 5'(MEM_TIMEOUT - 1)) begin
               state_d = S_FAULT;
               cnt_d   = 5'(MEM_TIMEOUT);
            end else if (cnt_q != 5'h1F) begin
               cnt_d = cnt_q + 5'd1;
            end
         end
         S_T2: state_d = S_T3;
         S_T3: begin
            op_d = dec;
            if (dec == '0)  state_d = S_FAULT;
            else if (unary) state_d = S_T5;
            else            state_d = S_T4;
         end
         S_T4: state_d = S_T5;
         S_T5: begin
            if (muldiv)       state_d = S_T6;
            else if (bus.run) state_d = S_T0;
            else              state_d = S_IDLE;
         end
         S_T6:    state_d = bus.run ? S_T0 : S_IDLE;
         S_FAULT: state_d = S_FAULT;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         op_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
      end
   end

   // Counter is zero only on the first T1 cycle, which is where PC is reloaded.
   always_comb begin
      bus.PCout    = 1'b0;
      bus.PCin     = 1'b0;
      bus.MARin    = 1'b0;
      bus.MDRin    = 1'b0;
      bus.MDRout   = 1'b0;
      bus.Read     = 1'b0;
      bus.IRin     = 1'b0;
      bus.Yin      = 1'b0;
      bus.Zin      = 1'b0;
      bus.Zlowout  = 1'b0;
      bus.Zhighout = 1'b0;
      bus.LOin     = 1'b0;
      bus.HIin     = 1'b0;
      bus.Gra      = 1'b0;
      bus.Grb      = 1'b0;
      bus.Grc      = 1'b0;
      bus.Rin      = 1'b0;
      bus.Rout     = 1'b0;
      bus.alu_op   = '0;
      bus.busy     = (state_q != S_IDLE) && (state_q != S_FAULT);
      bus.fault    = (state_q == S_FAULT);
      case (state_q)
         S_T0: begin
            bus.PCout      = 1'b1;
            bus.MARin      = 1'b1;
            bus.alu_op[13] = 1'b1;
            bus.Zin        = 1'b1;
         end
         S_T1: begin
            bus.Zlowout = 1'b1;
            bus.PCin    = (cnt_q == 5'd0);
            bus.Read    = 1'b1;
            bus.MDRin   = 1'b1;
         end
         S_T2: begin
            bus.MDRout = 1'b1;
            bus.IRin   = 1'b1;
         end
         S_T3: begin
            if (dec != '0) begin
               bus.Grb  = 1'b1;
               bus.Rout = 1'b1;
               if (unary) begin
                  bus.alu_op = dec;
                  bus.Zin    = 1'b1;
               end else begin
                  bus.Yin = 1'b1;
               end
            end
         end
         S_T4: begin
            bus.Grc    = 1'b1;
            bus.Rout   = 1'b1;
            bus.alu_op = op_q;
            bus.Zin    = 1'b1;
         end
         S_T5: begin
            bus.Zlowout = 1'b1;
            if (muldiv) begin
               bus.LOin = 1'b1;
            end else begin
               bus.Gra = 1'b1;
               bus.Rin = 1'b1;
            end
         end
         S_T6: begin
            bus.Zhighout = 1'b1;
            bus.HIin     = 1'b1;
         end
         default: ;
      endcase
   end

endmodule
